wbm_cmd_master: RTL and testbench



---
 rtl/wbm_cmd_master.sv | 156 +++++++++++++++
 tb/tb_wbm_cmd_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_cmd_master.sv
// ---------------------------------------------------------------------------
// wbm_cmd_master
//
// Single-beat Wishbone classic initiator. Converts a valid/ready command
// stream into one Wishbone read or write cycle at a time and returns the
// result on a valid/ready response stream. Completed transactions are
// counted for bandwidth debug.
//
// Optional feature (compile-time macro):
//   WBM_TIMEOUT_EN  - abort a bus cycle with rsp_err=1 when no ack arrives
//                     within TIMEOUT cycles. Undefined: wait for ack forever.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/adr/dat/sel          command fields (write flag, address, data, byte selects)
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat, rsp_err            read data (0 for writes/errors), timeout flag
//   wbm_cyc_o/stb_o/we_o        Wishbone control
//   wbm_adr_o/dat_o/sel_o       Wishbone address, write data, byte selects
//   wbm_dat_i, wbm_ack_i        Wishbone read data and acknowledge
//   txn_count                   completed transactions (ack or timeout), wraps
// ---------------------------------------------------------------------------
module wbm_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,

    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,

    output logic [15:0]         txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic accept;   // command taken this cycle
    logic ack_bus;  // ack that counts: only while the cycle is on the bus
    logic to_hit;   // no ack and the wait budget is exhausted
    logic done;     // bus cycle finishes at this edge (ack or timeout)

    assign accept  = (state == IDLE) && cmd_valid;
    assign ack_bus = (state == BUS) && wbm_ack_i;
    assign done    = ack_bus || to_hit;

`ifdef WBM_TIMEOUT_EN
    // At least 8 bits, wider when TIMEOUT needs it.
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TO_W-1:0] to_cnt;

    // The counter holds the number of ack-less BUS cycles already completed,
    // so this edge would make it reach TIMEOUT when it sits at TIMEOUT-1.
    // An ack in the same cycle takes priority.
    assign to_hit = (state == BUS) && !wbm_ack_i && (to_cnt == TO_W'(TIMEOUT - 1));

    // Held at zero outside BUS, so it is clear on every BUS entry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (state != BUS)) begin
            to_cnt <= '0;
        end else if (!wbm_ack_i) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_nxt = BUS;
            BUS:     if (done)      state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state: cyc/stb rise the cycle after
    // accept and fall at the completing edge; reset drops them at once.
    always_comb begin
        cmd_ready = (state == IDLE);
        wbm_cyc_o = (state == BUS);
        wbm_stb_o = (state == BUS);
        rsp_valid = (state == RESP);
    end

    // Bus request fields, response and transaction counter. Request fields
    // only load on accept, so they keep their last values after the cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            if (accept) begin
                wbm_we_o  <= cmd_we;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
                wbm_sel_o <= cmd_sel;
            end
            if (done) begin
                // Data only for an acked read; writes and timeouts return 0.
                rsp_dat   <= (ack_bus && !wbm_we_o) ? wbm_dat_i : '0;
                rsp_err   <= !ack_bus;
                txn_count <= txn_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wbm_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wbm_cmd_master
//
// Directed self-checking bench for wbm_cmd_master. The bench acts as both
// the command source and the Wishbone slave. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point.
// Timeout scenarios are compiled in when WBM_TIMEOUT_EN is defined
// (instance uses TIMEOUT=4).
// ---------------------------------------------------------------------------
module tb_wbm_cmd_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_adr;
    logic [DATA_W-1:0]   cmd_dat;
    logic [DATA_W/8-1:0] cmd_sel;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_dat;
    logic                rsp_err;
    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [ADDR_W-1:0]   wbm_adr_o;
    logic [DATA_W-1:0]   wbm_dat_o;
    logic [DATA_W/8-1:0] wbm_sel_o;
    logic [DATA_W-1:0]   wbm_dat_i;
    logic                wbm_ack_i;
    logic [15:0]         txn_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt;

    always #5 wb_clk_i = ~wb_clk_i;

    wbm_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(4)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .txn_count(txn_count)
    );

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        step();
        step();
        checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wbm_cyc_o); end
        checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wbm_stb_o); end
        checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wbm_we_o); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", wbm_adr_o); end
        checks++; if (wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat_o: got %h want 0", wbm_dat_o); end
        checks++; if (wbm_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", wbm_sel_o); end
        checks++; if (rsp_dat !== 32'h0) begin errors++; $display("FAIL reset_rsp_dat: got %h want 0", rsp_dat); end
        checks++; if (txn_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", txn_count); end
        wb_rst_i = 1'b0;
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_write_zero_wait();
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        step();                        // accept edge
        cmd_valid = 1'b0;
        checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b111) begin errors++; $display("FAIL wr_ctrl: got %b want 111", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
        checks++; if (wbm_adr_o !== 32'h3000_0004) begin errors++; $display("FAIL wr_adr: got %h want 30000004", wbm_adr_o); end
        checks++; if (wbm_dat_o !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_dat: got %h want a5a51234", wbm_dat_o); end
        checks++; if (wbm_sel_o !== 4'hF) begin errors++; $display("FAIL wr_sel: got %h want f", wbm_sel_o); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready_bus: got %b want 0", cmd_ready); end
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_FFFF;     // must not leak into a write response
        step();                        // ack edge
        wbm_ack_i = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if ({wbm_cyc_o, wbm_stb_o, rsp_valid} !== 3'b001) begin errors++; $display("FAIL wr_rsp_ctrl: got %b want 001", {wbm_cyc_o, wbm_stb_o, rsp_valid}); end
        checks++; if (rsp_dat !== 32'h0) begin errors++; $display("FAIL wr_rsp_dat: got %h want 0", rsp_dat); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_err: got %b want 0", rsp_err); end
        checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL wr_count: got %h want %h", txn_count, exp_cnt); end
        step();                        // RESP -> IDLE
        checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL wr_back_idle: got %b want 01", {rsp_valid, cmd_ready}); end
        checks++; if ({wbm_we_o, wbm_adr_o} !== {1'b1, 32'h3000_0004}) begin errors++; $display("FAIL wr_hold_after: got %h want 130000004", {wbm_we_o, wbm_adr_o}); end
    endtask

    task automatic test_read_zero_wait();
        issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        step();
        cmd_valid = 1'b0;
        checks++; if ({wbm_cyc_o, wbm_we_o} !== 2'b10) begin errors++; $display("FAIL rd_ctrl: got %b want 10", {wbm_cyc_o, wbm_we_o}); end
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hA5A5_1234;
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_dat !== 32'hA5A5_1234) begin errors++; $display("FAIL rd_rsp_dat: got %h want a5a51234", rsp_dat); end
        checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL rd_count: got %h want %h", txn_count, exp_cnt); end
        step();
    endtask

    task automatic test_wait_states();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        exp_cnt = 16'd0;
        issue(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'h3);
        step();
        issue(1'b0, 32'h1111_1111, 32'h2222_2222, 4'hC);  // changes must not reach the bus
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({wbm_cyc_o, wbm_stb_o} !== 2'b11) begin errors++; $display("FAIL ws_cyc_high[%0d]: got %b want 11", i, {wbm_cyc_o, wbm_stb_o}); end
            checks++; if ({wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {32'h3000_0010, 32'hDEAD_BEEF, 4'h3}) begin errors++; $display("FAIL ws_stable[%0d]: got %h want 30000010deadbeef3", i, {wbm_adr_o, wbm_dat_o, wbm_sel_o}); end
            checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL ws_count_bus[%0d]: got %h want 0", i, txn_count); end
            wbm_ack_i = (i == 4);
            step();
        end
        wbm_ack_i = 1'b0;
        checks++; if ({wbm_cyc_o, rsp_valid} !== 2'b01) begin errors++; $display("FAIL ws_drop: got %b want 01", {wbm_cyc_o, rsp_valid}); end
        checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL ws_count: got %h want 1", txn_count); end
        exp_cnt = 16'd1;
        step();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        step();
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BAD_CAFE;
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        exp_cnt = exp_cnt + 16'd1;
        issue(1'b1, 32'h3000_0024, 32'h1357_9BDF, 4'h1);  // waits behind the response
        for (int i = 0; i < 10; i++) begin
            checks++; if ({rsp_valid, cmd_ready, wbm_cyc_o} !== 3'b100) begin errors++; $display("FAIL bp_hold[%0d]: got %b want 100", i, {rsp_valid, cmd_ready, wbm_cyc_o}); end
            checks++; if (rsp_dat !== 32'h0BAD_CAFE) begin errors++; $display("FAIL bp_rsp_dat[%0d]: got %h want 0badcafe", i, rsp_dat); end
            step();
        end
        checks++; if (wbm_adr_o !== 32'h3000_0020) begin errors++; $display("FAIL bp_adr_held: got %h want 30000020", wbm_adr_o); end
        rsp_ready = 1'b1;
        step();                        // response consumed, back in IDLE
        checks++; if ({rsp_valid, cmd_ready, wbm_cyc_o} !== 3'b010) begin errors++; $display("FAIL bp_release: got %b want 010", {rsp_valid, cmd_ready, wbm_cyc_o}); end
        step();                        // new command accepted here
        cmd_valid = 1'b0;
        checks++; if ({wbm_cyc_o, wbm_adr_o} !== {1'b1, 32'h3000_0024}) begin errors++; $display("FAIL bp_next_cmd: got %h want 130000024", {wbm_cyc_o, wbm_adr_o}); end
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL bp_count: got %h want %h", txn_count, exp_cnt); end
        step();
    endtask

    task automatic test_back_to_back();
        // Command held valid and ack held high: one issue every 3 cycles.
        wbm_ack_i = 1'b1;
        issue(1'b1, 32'h3000_0100, 32'h0000_0001, 4'hF);
        step();
        issue(1'b1, 32'h3000_0104, 32'h0000_0002, 4'hF);
        checks++; if ({wbm_cyc_o, wbm_adr_o} !== {1'b1, 32'h3000_0100}) begin errors++; $display("FAIL b2b_first: got %h want 130000100", {wbm_cyc_o, wbm_adr_o}); end
        step();
        checks++; if ({wbm_cyc_o, rsp_valid} !== 2'b01) begin errors++; $display("FAIL b2b_resp1: got %b want 01", {wbm_cyc_o, rsp_valid}); end
        step();
        checks++; if ({wbm_cyc_o, cmd_ready} !== 2'b01) begin errors++; $display("FAIL b2b_idle: got %b want 01", {wbm_cyc_o, cmd_ready}); end
        step();
        cmd_valid = 1'b0;
        checks++; if ({wbm_cyc_o, wbm_adr_o} !== {1'b1, 32'h3000_0104}) begin errors++; $display("FAIL b2b_second: got %h want 130000104", {wbm_cyc_o, wbm_adr_o}); end
        step();
        wbm_ack_i = 1'b0;
        exp_cnt = exp_cnt + 16'd2;
        checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL b2b_count: got %h want %h", txn_count, exp_cnt); end
        step();
    endtask

`ifdef WBM_TIMEOUT_EN
    task automatic test_timeout();
        rsp_ready = 1'b0;
        wbm_dat_i = 32'h7777_7777;
        issue(1'b0, 32'h3000_0200, 32'h0, 4'hF);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (wbm_cyc_o !== 1'b1) begin errors++; $display("FAIL to_cyc_high[%0d]: got %b want 1", i, wbm_cyc_o); end
            step();
        end
        exp_cnt = exp_cnt + 16'd1;
        checks++; if ({wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err} !== 4'b0011) begin errors++; $display("FAIL to_abort: got %b want 0011", {wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err}); end
        checks++; if (rsp_dat !== 32'h0) begin errors++; $display("FAIL to_rsp_dat: got %h want 0", rsp_dat); end
        checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL to_count: got %h want %h", txn_count, exp_cnt); end
        step();
        wbm_ack_i = 1'b1;              // stray ack two cycles after the abort
        step();
        wbm_ack_i = 1'b0;
        checks++; if ({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b011, 32'h0}) begin errors++; $display("FAIL to_stray_ack: got %h want 300000000", {wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}); end
        checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL to_stray_count: got %h want %h", txn_count, exp_cnt); end
        rsp_ready = 1'b1;
        step();

        // Ack on the 4th BUS cycle coincides with the limit and wins.
        issue(1'b0, 32'h3000_0204, 32'h0, 4'hF);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h7777_7777}) begin errors++; $display("FAIL to_ack_wins: got %h want 277777777", {rsp_valid, rsp_err, rsp_dat}); end
        checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL to_ack_wins_count: got %h want %h", txn_count, exp_cnt); end
        wbm_dat_i = 32'h0;
        step();
    endtask
`endif

    task automatic test_reset_mid_bus();
        issue(1'b1, 32'h3000_0300, 32'h5555_AAAA, 4'hF);
        step();                        // 1st BUS cycle
        cmd_valid = 1'b0;
        step();                        // 2nd BUS cycle
        checks++; if ({wbm_cyc_o, txn_count} !== {1'b1, exp_cnt}) begin errors++; $display("FAIL rst_pre: got %h want %h", {wbm_cyc_o, txn_count}, {1'b1, exp_cnt}); end
        wb_rst_i  = 1'b1;
        wbm_ack_i = 1'b1;              // reset must win over a coincident ack
        step();
        wbm_ack_i = 1'b0;
        checks++; if ({wbm_cyc_o, wbm_stb_o, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl: got %b want 000", {wbm_cyc_o, wbm_stb_o, rsp_valid}); end
        checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count: got %h want 0", txn_count); end
        wb_rst_i = 1'b0;
        step();
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL rst_mid_release: got %b want 10", {cmd_ready, rsp_valid}); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_count_wrap();
        force dut.txn_count = 16'hFFFF;
        release dut.txn_count;
        issue(1'b1, 32'h3000_0400, 32'h0, 4'hF);
        step();
        cmd_valid = 1'b0;
        checks++; if (txn_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", txn_count); end
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        checks++; if (txn_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0", txn_count); end
        step();
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        exp_cnt   = 16'd0;

        test_reset();
        test_write_zero_wait();
        test_read_zero_wait();
        test_wait_states();
        test_backpressure();
        test_back_to_back();
`ifdef WBM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_bus();
        test_count_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
